// File: rtl/controller_events_pkg.sv
// Shared constants and types for the controller event block: button indices,
// event code type, auto-repeat state encoding and the event priority encoder.
package controller_pkg;

    localparam int NUM_BUTTONS = 12;
    localparam int NUM_DIRS    = 4;

    localparam int BTN_UP    = 11;
    localparam int BTN_DOWN  = 10;
    localparam int BTN_LEFT  = 9;
    localparam int BTN_RIGHT = 8;
    localparam int BTN_A     = 7;
    localparam int BTN_B     = 6;
    localparam int BTN_C     = 5;
    localparam int BTN_X     = 4;
    localparam int BTN_Y     = 3;
    localparam int BTN_Z     = 2;
    localparam int BTN_START = 1;
    localparam int BTN_MODE  = 0;

    // Direction buttons occupy the top NUM_DIRS bits, starting at BTN_RIGHT.
    localparam int DIR_BASE = BTN_RIGHT;

    typedef logic [3:0] event_code_t;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    function automatic event_code_t highest_index(input logic [NUM_BUTTONS-1:0] vec);
        event_code_t code;
        code = 4'd0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (vec[i]) begin
                code = event_code_t'(i);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/controller_events_if.sv
// Valid/ready event channel from the controller event block to the game logic.
interface controller_events_if;
    import controller_pkg::*;

    logic        event_valid;
    event_code_t event_code;
    logic        event_ready;

    modport master (output event_valid, output event_code, input event_ready);
    modport slave  (input event_valid, input event_code, output event_ready);

endinterface

// File: rtl/controller_events_debounce.sv
// Single-bit debouncer: the held state follows the raw input only after it has
// differed for DEBOUNCE_CYCLES consecutive cycles.
module controller_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 16000
) (
    input  logic clk,
    input  logic reset_fixed,
    input  logic button,
    output logic held
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 32'd1);

    logic [15:0] cnt_d, cnt_q;
    logic        held_d, held_q;

    // Any agreeing sample restarts the run of differing cycles.
    always_comb begin
        cnt_d  = cnt_q;
        held_d = held_q;
        if (button == held_q) begin
            cnt_d = 16'd0;
        end else if (cnt_q == CNT_LAST) begin
            held_d = button;
            cnt_d  = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_fixed) begin
        if (!reset_fixed) begin
            cnt_q  <= 16'd0;
            held_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            held_q <= held_d;
        end
    end

    assign held = held_q;

endmodule

// File: rtl/controller_events.sv
// Debounces the 12 controller buttons and turns presses into prioritised
// events on a valid/ready channel. Define CONTROLLER_AUTOREPEAT_EN to add
// auto-repeat on the four direction buttons.
module controller_events
    import controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic                   clk,
    input  logic                   reset_fixed,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   enable,
    output logic [NUM_BUTTONS-1:0] held,
    controller_events_if.master    ev
);

    logic [NUM_BUTTONS-1:0] held_s;
    logic [NUM_BUTTONS-1:0] prev_d, prev_q;
    logic [NUM_BUTTONS-1:0] rise_d, rise_q;
    logic [NUM_BUTTONS-1:0] pending_d, pending_q;
    logic [NUM_BUTTONS-1:0] clr_s;
    logic [NUM_BUTTONS-1:0] tick_s;
    logic                   valid_s;
    event_code_t            code_s;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_db
        controller_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk         (clk),
            .reset_fixed (reset_fixed),
            .button      (buttons[i]),
            .held        (held_s[i])
        );
    end

`ifdef CONTROLLER_AUTOREPEAT_EN
    localparam logic [23:0] DELAY_LAST  = 24'(REPEAT_DELAY - 32'd1);
    localparam logic [23:0] PERIOD_LAST = 24'(REPEAT_PERIOD - 32'd1);

    rpt_state_e           rpt_state_d [NUM_DIRS];
    rpt_state_e           rpt_state_q [NUM_DIRS];
    logic [23:0]          rpt_cnt_d   [NUM_DIRS];
    logic [23:0]          rpt_cnt_q   [NUM_DIRS];
    logic [NUM_DIRS-1:0]  dir_tick_s;

    // Repeat sequencers; a release or disable forces IDLE and wins over a tick.
    always_comb begin
        for (int d = 0; d < NUM_DIRS; d++) begin
            rpt_state_d[d] = rpt_state_q[d];
            rpt_cnt_d[d]   = rpt_cnt_q[d];
            dir_tick_s[d]  = 1'b0;
            if (!enable || !held_s[DIR_BASE + d]) begin
                rpt_state_d[d] = RPT_IDLE;
                rpt_cnt_d[d]   = 24'd0;
            end else begin
                case (rpt_state_q[d])
                    RPT_IDLE: begin
                        rpt_cnt_d[d] = 24'd0;
                        if (rise_q[DIR_BASE + d]) begin
                            rpt_state_d[d] = RPT_DELAY;
                        end else begin
                            rpt_state_d[d] = RPT_IDLE;
                        end
                    end
                    RPT_DELAY: begin
                        if (rpt_cnt_q[d] == DELAY_LAST) begin
                            dir_tick_s[d]  = 1'b1;
                            rpt_state_d[d] = RPT_REPEAT;
                            rpt_cnt_d[d]   = 24'd0;
                        end else begin
                            rpt_cnt_d[d] = rpt_cnt_q[d] + 24'd1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (rpt_cnt_q[d] == PERIOD_LAST) begin
                            dir_tick_s[d] = 1'b1;
                            rpt_cnt_d[d]  = 24'd0;
                        end else begin
                            rpt_cnt_d[d] = rpt_cnt_q[d] + 24'd1;
                        end
                    end
                    default: begin
                        rpt_state_d[d] = RPT_IDLE;
                        rpt_cnt_d[d]   = 24'd0;
                    end
                endcase
            end
        end
    end

    // Repeat sequencer registers.
    always_ff @(posedge clk or negedge reset_fixed) begin
        if (!reset_fixed) begin
            for (int d = 0; d < NUM_DIRS; d++) begin
                rpt_state_q[d] <= RPT_IDLE;
                rpt_cnt_q[d]   <= 24'd0;
            end
        end else begin
            rpt_state_q <= rpt_state_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end

    assign tick_s = {dir_tick_s, 8'd0};
`else
    logic unused_repeat_s;
    assign unused_repeat_s = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign tick_s          = 12'd0;
`endif

    assign valid_s = |pending_q;
    assign code_s  = highest_index(pending_q);

    // Edges seen while disabled are dropped so a held button stays silent later.
    always_comb begin
        prev_d    = held_s;
        rise_d    = held_s & ~prev_q & {NUM_BUTTONS{enable}};
        clr_s     = 12'd0;
        if (valid_s && ev.event_ready) begin
            clr_s[code_s] = 1'b1;
        end else begin
            clr_s = 12'd0;
        end
        if (enable) begin
            pending_d = (pending_q & ~clr_s) | rise_q | tick_s;
        end else begin
            pending_d = 12'd0;
        end
    end

    // Edge detect and pending event registers.
    always_ff @(posedge clk or negedge reset_fixed) begin
        if (!reset_fixed) begin
            prev_q    <= 12'd0;
            rise_q    <= 12'd0;
            pending_q <= 12'd0;
        end else begin
            prev_q    <= prev_d;
            rise_q    <= rise_d;
            pending_q <= pending_d;
        end
    end

    assign held           = held_s;
    assign ev.event_valid = valid_s;
    assign ev.event_code  = code_s;

endmodule

// File: doc/controller_events.md
# controller_events

Converts the 12-bit held-button vector produced by the controller reader into debounced, discrete press events for the sudoku game logic. Each button is debounced, rising edges are latched as pending events, and direction buttons optionally auto-repeat while held. Pending events are delivered one at a time, highest priority first, over a valid/ready handshake to the cursor/cell-entry logic.

## Interface
- DEBOUNCE_CYCLES, 16000, consecutive cycles a raw bit must differ from its debounced value before the change is accepted (1..65535)
- REPEAT_DELAY, 12500000, cycles from debounced press to first repeat tick (1..2^24-1)
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat ticks (1..2^24-1)
- clk  input  1  system clock
- reset_fixed  input  1  asynchronous, active-low reset
- buttons  input  12  raw held state, order {up,down,left,right,a,b,c,x,y,z,start,mode}; bit 11 = up, bit 0 = mode; 1 = pressed
- enable  input  1  event generation enable; low flushes and suppresses events
- held  output  12  debounced button state, same bit order
- event_valid  output  1  at least one event pending
- event_code  output  4  bit index (0..11) of the pending event being offered
- event_ready  input  1  consumer accepts event when high with event_valid

## Operation
- Debounce, per bit: 16-bit counter; if buttons[i] == held[i], counter cleared; else counter increments; when counter == DEBOUNCE_CYCLES-1 and input still differs, held[i] <= buttons[i], counter cleared.
- Press detect: rise[i] = held[i] rising (registered previous vs current held).
- Auto-repeat, bits 11..8 only, one FSM + 24-bit counter per direction:
  - IDLE: on rise -> DELAY, counter 0.
  - DELAY: count; at REPEAT_DELAY-1 -> tick, REPEAT, counter 0.
  - REPEAT: count; at REPEAT_PERIOD-1 -> tick, counter 0.
  - held[i] low in any state -> IDLE, counter 0 (overrides tick that cycle).
- Pending register pending[11:0]: set by rise[i] or tick[i]; clear of bit event_code when event_valid && event_ready. Simultaneous set and clear of same bit -> stays set.
- Multiple rises in one cycle -> all latched. Already-pending bit re-set -> single event (no counting).
- event_valid = |pending; event_code = highest set index (up highest, mode lowest). Combinational from pending.
- enable low: pending cleared, sets suppressed, repeat FSMs held in IDLE; debounce and held continue. Buttons already held when enable rises generate no event until released and pressed again.

## Timing
- Reset: held = 0, pending = 0, event_valid = 0, event_code = 0, all counters 0, FSMs IDLE.
- Input change to held: DEBOUNCE_CYCLES cycles after first differing cycle (stable input).
- held rise to event_valid: 2 cycles (edge register, pending register).
- Handshake: accept on clk edge with valid && ready; next-priority event offered the following cycle; event_code stable while valid && !ready unless a higher-priority bit is set.
- First repeat tick REPEAT_DELAY cycles after entering DELAY; then every REPEAT_PERIOD cycles.
- Reset mid-operation: all state returns to reset values immediately (async); events pending are discarded.

## Configuration
- CONTROLLER_AUTOREPEAT_EN defined: repeat FSMs and counters present as above.
- Not defined: no repeat logic; tick = 0; exactly one event per debounced press; REPEAT_DELAY/REPEAT_PERIOD ignored.

## Structure
- Package controller_pkg: button index constants (BTN_UP=11 ... BTN_MODE=0), NUM_BUTTONS=12, event code type (4-bit), repeat FSM state enum.
- Sub-module controller_debounce_bit: one bit of debounce (counter, held output), instantiated 12 times.

## Test plan
(DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, enable=1, event_ready=1 unless stated)
- buttons[7]=1 for 3 cycles then 0 -> held stays 0, no event.
- buttons[7]=1 held -> held[7]=1 after 4 cycles, event_valid one cycle with event_code=7, then none while held.
- buttons[11] and buttons[0] rise same cycle, event_ready=0 for 5 cycles then 1 -> code 11 held stable, accepted, then code 0 next cycle, then valid=0.
- buttons[8] held 30 cycles (AUTOREPEAT_EN) -> events code 8 at press, +10, then every 3 cycles; release stops repeats; without macro only one event.
- enable=0 with pending bit 5, then press bit 4 -> pending cleared, no event; enable=1 while bit 4 held -> no event until re-press.
- reset_fixed asserted with events pending and repeat active -> event_valid=0, held=0 immediately; no events after release until new press.
